mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares the single-port 16-bit program/data memory of the RISC processor between the CPU (instruction fetch, LD, LDI, STO) and the program loader/debug port. It sits between the control unit/execution unit memory interface and the memory. It grants one access per cycle using round-robin priority. It supports a loader lock for exclusive burst ownership, and returns read data with a one-cycle latency, tagged to the requester that was granted.

## Interface
- AW, 8: memory address width (word addresses).
- DW, 16: data width.
- clk  in  1: system clock, rising-edge.
- reset  in  1: asynchronous, active-high reset.
- c_req  in  1: CPU access request; held until c_gnt.
- c_we  in  1: CPU write (1) / read (0).
- c_addr  in  AW: CPU address.
- c_wdata  in  DW: CPU write data.
- c_gnt  out  1: CPU access performed this cycle.
- c_rvalid  out  1: rdata holds the CPU read result.
- l_req, l_we, l_addr, l_wdata  in  1/1/AW/DW: loader request fields, same rules as the CPU fields.
- l_lock  in  1: loader requests exclusive ownership.
- l_gnt, l_rvalid  out  1: loader grant and read-valid.
- rdata  out  DW: read data, shared by both requesters.
- mem_en, mem_we  out  1: memory enable and write strobe.
- mem_addr  out  AW: memory address.
- mem_wdata  out  DW: memory write data.
- mem_rdata  in  DW: memory synchronous read data, valid the cycle after mem_en with mem_we=0.
- locked  out  1: arbiter is in LOCKED state (status LED).

## Operation
- FSM states: ARB, LOCKED.
- ARB, single request: the requester is granted.
- ARB, both requesting: grant the requester that is not `last`. `last` is a 1-bit register, 0 = CPU, 1 = loader. It updates to the granted port on every grant.
- ARB to LOCKED: when l_lock=1 and the loader is granted in the same cycle.
- LOCKED:
  - Only the loader is granted, whenever l_req=1.
  - c_gnt is 0 and CPU requests stall.
  - Return to ARB on the first cycle that l_lock=0. The transition is registered, so the CPU can be granted from the following cycle.
- l_lock=1 without a loader grant does not lock.
- An l_lock high with no l_req keeps LOCKED. The CPU remains blocked; the loader owns that risk.
- Memory drive:
  - mem_en = c_gnt | l_gnt.
  - mem_we, mem_addr and mem_wdata are muxed from the granted port.
  - All are zero when no grant is given.
- Read return: a granted read sets a registered tag. The following cycle asserts exactly one of c_rvalid or l_rvalid, and rdata = mem_rdata.
- Writes produce no rvalid.
- When no rvalid is asserted, rdata holds its last returned value.
- Grants are mutually exclusive, and at most one access occurs per cycle.
- Back-to-back accesses are allowed. A requester holding req high is granted on consecutive cycles if it is uncontested, or every other cycle under contention.

## Timing
- Reset values:
  - State = ARB; last = 1, so the CPU wins the first contention.
  - All gnt, rvalid, mem_en, mem_we and locked are 0.
  - mem_addr, mem_wdata and rdata are 0.
- c_gnt, l_gnt and the mem_* outputs are combinational from the current req/lock inputs and the registered state/last.
- Requesters must present req, we, addr and wdata stable before the clock edge. Fields are sampled by memory at the edge that ends the grant cycle.
- Read latency: rvalid is asserted 1 cycle after gnt, for 1 cycle.
- State, last and the rvalid tag change only on the rising clk edge.
- Reset asserted mid-operation:
  - All outputs clear immediately.
  - A pending rvalid is discarded and LOCKED is abandoned.
  - Deassertion returns to ARB.

## Structure
- Shared package `cpu_pkg` holds:
  - AW/DW defaults.
  - State encodings ARB=0, LOCKED=1.
  - Port IDs PORT_CPU=0, PORT_LDR=1.
- One sub-module is natural: `rr_pick2`, a combinational two-request round-robin selector taking (req0, req1, last) and returning (gnt0, gnt1).
- The FSM, the read-tag register and the memory mux stay in `mem_arbiter`.

## Test plan
- Reset, then idle: all outputs 0 and locked=0. Hold reset mid-read: c_rvalid never asserts.
- CPU read at addr 0x10, memory holding 0x7A05: c_gnt is asserted in cycle 0. In cycle 1, c_rvalid=1 and rdata=0x7A05; l_rvalid stays 0.
- Both requesters reading continuously from reset: grants alternate CPU, loader, CPU, loader. Each rvalid is tagged to the matching port, and no cycle has both gnt asserted.
- Loader writes 0xF0F0 to 0x20 while the CPU reads 0x20 in the same cycle: the loader wins if last=CPU. The CPU is granted the next cycle and reads 0xF0F0.
- Loader lock burst: l_lock=1 with 4 writes to 0x00–0x03 while c_req=1. locked=1 and c_gnt=0 throughout. Drop l_lock: locked goes to 0 and c_gnt=1 on the next cycle.
- Loader write with l_lock=0 and l_we=1: no rvalid follows, and mem_we=1 only in the grant cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the memory arbiter: default widths, FSM state
// encoding and requester port identifiers.
package cpu_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-request round-robin selector. A lone requester always
// wins; on contention the requester that was not served last wins.
module rr_pick2
  import cpu_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt0,
  output logic gnt1
);

  // req0 is the CPU, req1 is the loader; last names the most recent winner.
  always_comb begin
    gnt0 = req0 & (~req1 | (last == PORT_LDR));
    gnt1 = req1 & (~req0 | (last == PORT_CPU));
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between the CPU and the program
// loader. One access per cycle, round-robin on contention, an exclusive
// loader lock, and one-cycle read return tagged to the requester.
//
// Handshake: a requester raises req with we/addr/wdata stable and holds them
// until it sees gnt high in the same cycle; the access happens at the edge
// that ends that cycle. A granted read returns rvalid for exactly one cycle
// on the following cycle with rdata valid alongside it. Writes return nothing.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  input  logic          l_lock,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          locked
);

  arb_state_t    state_q, state_d;
  logic          last_q;
  logic          cpu_tag_q, ldr_tag_q;
  logic [DW-1:0] rdata_q;
  logic          pick_c, pick_l;
  logic          ret_valid;

  rr_pick2 u_pick (
    .req0 (c_req),
    .req1 (l_req),
    .last (last_q),
    .gnt0 (pick_c),
    .gnt1 (pick_l)
  );

  // FSM state register; reset abandons any lock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ARB;
    else       state_q <= state_d;
  end

  // Grant decision and next state. Reset forces grants low immediately.
  always_comb begin
    c_gnt   = 1'b0;
    l_gnt   = 1'b0;
    state_d = state_q;
    case (state_q)
      ARB: begin
        c_gnt = pick_c;
        l_gnt = pick_l;
        if (pick_l && l_lock) state_d = LOCKED;
      end
      LOCKED: begin
        l_gnt = l_req;
        if (!l_lock) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
    if (reset) begin
      c_gnt = 1'b0;
      l_gnt = 1'b0;
    end
  end

  // Memory port mux: driven from the granted requester, all zero when idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (c_gnt) begin
      mem_en    = 1'b1;
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end else if (l_gnt) begin
      mem_en    = 1'b1;
      mem_we    = l_we;
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
    end
  end

  // Round-robin history: remembers which port took the latest grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               last_q <= PORT_LDR;
    else if (c_gnt || l_gnt) last_q <= l_gnt ? PORT_LDR : PORT_CPU;
  end

  // Read-return tag: marks which port owns the data arriving next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_tag_q <= 1'b0;
      ldr_tag_q <= 1'b0;
    end else begin
      cpu_tag_q <= c_gnt & ~c_we;
      ldr_tag_q <= l_gnt & ~l_we;
    end
  end

  // Hold the most recently returned word so rdata stays put between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          rdata_q <= '0;
    else if (ret_valid) rdata_q <= mem_rdata;
  end

  assign ret_valid = cpu_tag_q | ldr_tag_q;
  assign c_rvalid  = cpu_tag_q;
  assign l_rvalid  = ldr_tag_q;
  assign rdata     = ret_valid ? mem_rdata : rdata_q;
  assign locked    = (state_q == LOCKED);

endmodule
